// File: rtl/matrix_seq_ctrl_pkg.sv
// Shared definitions for the row-serial matrix sequencer.
// Contents:
//   - opcode encodings carried in instr[4:2]
//   - FSM state encoding and row-ALU operation encoding
//   - size-code decode, instruction legality check
//   - element pack/unpack bit-offset function (element (0,0) in the MSBs)
package matrix_pkg;

  localparam logic [2:0] OP_ADD       = 3'b000;
  localparam logic [2:0] OP_SUB       = 3'b001;
  localparam logic [2:0] OP_MULT_MAT  = 3'b010;
  localparam logic [2:0] OP_MULT_INT  = 3'b011;
  localparam logic [2:0] OP_TRANSPOSE = 3'b101;
  localparam logic [2:0] OP_OPPOSITE  = 3'b110;

  // Row/column counters and the decoded "last index" (N-1) share this width;
  // a 2-bit size code never produces an index above 4.
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SCALE,
    ALU_NEG,
    ALU_PASS
  } alu_op_t;

  // N-1 for size code (N = code + 2).
  function automatic logic [CNT_W-1:0] size_last(input logic [1:0] code);
    return {1'b0, code} + CNT_W'(1);
  endfunction

  function automatic logic instr_legal(input logic [4:0] instr, input int max_n);
    logic op_ok;
    op_ok = (instr[4:2] != 3'b100) && (instr[4:2] != 3'b111);
    return op_ok && ((int'(instr[1:0]) + 2) <= max_n);
  endfunction

  // Element-wise opcodes map onto the row ALU; everything else passes through
  // (TRANSPOSE reorders lanes in front of the ALU, MULT_MAT bypasses it).
  function automatic alu_op_t alu_op(input logic [2:0] op);
    case (op)
      OP_ADD:      return ALU_ADD;
      OP_SUB:      return ALU_SUB;
      OP_MULT_INT: return ALU_SCALE;
      OP_OPPOSITE: return ALU_NEG;
      default:     return ALU_PASS;
    endcase
  endfunction

  // LSB position of element (r,c) in a row-major packed matrix with (0,0) at the top.
  function automatic int elem_lsb(input int r, input int c, input int max_n, input int elem_w);
    return (max_n * max_n - 1 - (r * max_n + c)) * elem_w;
  endfunction

endpackage

// File: rtl/matrix_seq_ctrl_if.sv
// Handshake bus of the matrix sequencer.
//   in_valid/in_ready  : instruction + operand request channel
//   instr              : [4:2] opcode, [1:0] size code
//   mat_a/mat_b        : packed MAX_N x MAX_N operands, row-major, (0,0) in MSBs
//   out_valid/out_ready: result channel with back-pressure
//   result/ovf/err     : packed result, sticky overflow, illegal-instruction flag
// master = requester/consumer side, slave = sequencer side.
interface matrix_seq_ctrl_if #(
  parameter int ELEM_W = 8,
  parameter int MAX_N  = 5
);
  localparam int MAT_W = MAX_N * MAX_N * ELEM_W;

  logic             in_valid;
  logic             in_ready;
  logic [4:0]       instr;
  logic [MAT_W-1:0] mat_a;
  logic [MAT_W-1:0] mat_b;
  logic             out_valid;
  logic             out_ready;
  logic [MAT_W-1:0] result;
  logic             ovf;
  logic             err;

  modport master (
    output in_valid, instr, mat_a, mat_b, out_ready,
    input  in_ready, out_valid, result, ovf, err
  );

  modport slave (
    input  in_valid, instr, mat_a, mat_b, out_ready,
    output in_ready, out_valid, result, ovf, err
  );
endinterface

// File: rtl/matrix_seq_ctrl_row_alu.sv
// matrix_row_alu: combinational MAX_N-lane element-wise unit.
//   i_op      : ADD / SUB / SCALE (a * scalar) / NEG / PASS
//   i_lane_en : lanes outside the active NxN window produce 0 and never flag overflow
//   i_a, i_b  : one row of each operand, lane c = column c
//   i_scalar  : multiplier for SCALE
//   o_res     : per-lane result, clamped (SATURATE=1) or wrapped (SATURATE=0)
//   o_ovf     : OR of per-lane out-of-range flags
module matrix_row_alu
  import matrix_pkg::*;
#(
  parameter int ELEM_W   = 8,
  parameter int MAX_N    = 5,
  parameter bit SATURATE = 1'b1
) (
  input  alu_op_t                         i_op,
  input  logic [MAX_N-1:0]                i_lane_en,
  input  logic [MAX_N-1:0][ELEM_W-1:0]    i_a,
  input  logic [MAX_N-1:0][ELEM_W-1:0]    i_b,
  input  logic [ELEM_W-1:0]               i_scalar,
  output logic [MAX_N-1:0][ELEM_W-1:0]    o_res,
  output logic                            o_ovf
);
  // Twice the element width holds every ADD/SUB/NEG/SCALE result exactly.
  localparam int WIDE = 2 * ELEM_W;

  logic [MAX_N-1:0] w_lane_ovf;

  for (genvar g = 0; g < MAX_N; g++) begin : g_lane
    logic signed [WIDE-1:0]   w_a, w_b, w_s, w_full;
    logic                     w_ovf;
    logic [ELEM_W-1:0]        w_sat;

    assign w_a = $signed({{ELEM_W{i_a[g][ELEM_W-1]}}, i_a[g]});
    assign w_b = $signed({{ELEM_W{i_b[g][ELEM_W-1]}}, i_b[g]});
    assign w_s = $signed({{ELEM_W{i_scalar[ELEM_W-1]}}, i_scalar});

    always_comb begin
      w_full = w_a;
      case (i_op)
        ALU_ADD:   w_full = w_a + w_b;
        ALU_SUB:   w_full = w_a - w_b;
        ALU_SCALE: w_full = w_a * w_s;
        ALU_NEG:   w_full = -w_a;
        default:   w_full = w_a;
      endcase
    end

    // In range exactly when every bit from the element sign bit upward agrees.
    assign w_ovf = !((&w_full[WIDE-1:ELEM_W-1]) || !(|w_full[WIDE-1:ELEM_W-1]));
    assign w_sat = w_full[WIDE-1] ? {1'b1, {(ELEM_W-1){1'b0}}} : {1'b0, {(ELEM_W-1){1'b1}}};

    assign w_lane_ovf[g] = i_lane_en[g] & w_ovf;
    assign o_res[g] = !i_lane_en[g]          ? '0    :
                      (w_ovf && SATURATE)    ? w_sat :
                                               w_full[ELEM_W-1:0];
  end

  assign o_ovf = |w_lane_ovf;

endmodule

// File: rtl/matrix_seq_ctrl.sv
// matrix_seq_ctrl: row-serial matrix coprocessor control unit.
//   clk    : single clock
//   rst    : synchronous, active-low reset
//   io_mat : slave side of matrix_seq_ctrl_if (request, operands, result, flags)
// Operation: IDLE accepts one instruction with both operands, EXEC produces one
// result row per cycle (element-wise ops, TRANSPOSE) or one element per cycle
// (MULT_MAT), DONE holds the result until the consumer takes it.
module matrix_seq_ctrl
  import matrix_pkg::*;
#(
  parameter int ELEM_W   = 8,
  parameter int MAX_N    = 5,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  matrix_seq_ctrl_if.slave io_mat
);
  // Dot-product accumulator: full product width plus growth for MAX_N terms.
  localparam int ACC_W = 2 * ELEM_W + $clog2(MAX_N);

  typedef logic [MAX_N-1:0][MAX_N-1:0][ELEM_W-1:0] mat_t;

  mat_t             w_in_a, w_in_b;
  mat_t             r_a, r_b, r_res;
  state_t           r_state;
  logic [2:0]       r_op;
  logic [CNT_W-1:0] r_last;
  logic [CNT_W-1:0] r_row, r_col;
  logic             r_in_ready, r_out_valid, r_ovf, r_err;

  // Unpack request operands and pack the result register onto the bus.
  for (genvar r = 0; r < MAX_N; r++) begin : g_row
    for (genvar c = 0; c < MAX_N; c++) begin : g_col
      assign w_in_a[r][c] = io_mat.mat_a[elem_lsb(r, c, MAX_N, ELEM_W) +: ELEM_W];
      assign w_in_b[r][c] = io_mat.mat_b[elem_lsb(r, c, MAX_N, ELEM_W) +: ELEM_W];
      assign io_mat.result[elem_lsb(r, c, MAX_N, ELEM_W) +: ELEM_W] = r_res[r][c];
    end
  end

  assign io_mat.in_ready  = r_in_ready;
  assign io_mat.out_valid = r_out_valid;
  assign io_mat.ovf       = r_ovf;
  assign io_mat.err       = r_err;

  // ---------------- row datapath ----------------
  logic [MAX_N-1:0][ELEM_W-1:0] w_lane_a, w_lane_b, w_lane_res;
  logic [MAX_N-1:0]             w_lane_en;
  logic                         w_row_ovf;
  alu_op_t                      w_alu_op;

  // TRANSPOSE feeds column r_row of A into the lanes and lets the ALU pass it.
  always_comb begin
    w_lane_a  = '0;
    w_lane_b  = '0;
    w_lane_en = '0;
    for (int c = 0; c < MAX_N; c++) begin
      w_lane_a[c]  = (r_op == OP_TRANSPOSE) ? r_a[c][r_row] : r_a[r_row][c];
      w_lane_b[c]  = r_b[r_row][c];
      w_lane_en[c] = (CNT_W'(c) <= r_last);
    end
  end

  assign w_alu_op = alu_op(r_op);

  matrix_row_alu #(
    .ELEM_W   (ELEM_W),
    .MAX_N    (MAX_N),
    .SATURATE (SATURATE)
  ) u_row_alu (
    .i_op      (w_alu_op),
    .i_lane_en (w_lane_en),
    .i_a       (w_lane_a),
    .i_b       (w_lane_b),
    .i_scalar  (r_b[0][0]),
    .o_res     (w_lane_res),
    .o_ovf     (w_row_ovf)
  );

  // ---------------- MULT_MAT dot product for element (r_row, r_col) ----------------
  logic signed [ACC_W-1:0] w_acc;
  logic [ELEM_W-1:0]       w_mm_elem;
  logic                    w_mm_ovf;

  always_comb begin
    w_acc = '0;
    for (int k = 0; k < MAX_N; k++) begin
      // Padding terms beyond N must not contribute.
      if (CNT_W'(k) <= r_last)
        w_acc = w_acc
              + $signed({{(ACC_W-ELEM_W){r_a[r_row][k][ELEM_W-1]}}, r_a[r_row][k]})
              * $signed({{(ACC_W-ELEM_W){r_b[k][r_col][ELEM_W-1]}}, r_b[k][r_col]});
    end
    w_mm_ovf = !((&w_acc[ACC_W-1:ELEM_W-1]) || !(|w_acc[ACC_W-1:ELEM_W-1]));
    w_mm_elem = w_acc[ELEM_W-1:0];
    if (w_mm_ovf && SATURATE)
      w_mm_elem = w_acc[ACC_W-1] ? {1'b1, {(ELEM_W-1){1'b0}}} : {1'b0, {(ELEM_W-1){1'b1}}};
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_res       <= '0;
      r_ovf       <= 1'b0;
      r_err       <= 1'b0;
      r_op        <= '0;
      r_last      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_a         <= '0;
      r_b         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_in_ready && io_mat.in_valid) begin
            r_in_ready <= 1'b0;
            r_a        <= w_in_a;
            r_b        <= w_in_b;
            r_op       <= io_mat.instr[4:2];
            r_last     <= size_last(io_mat.instr[1:0]);
            r_err      <= !instr_legal(io_mat.instr, MAX_N);
            r_ovf      <= 1'b0;
            r_res      <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_state    <= S_EXEC;
          end else begin
            r_in_ready <= 1'b1;
          end
        end

        S_EXEC: begin
          // An illegal instruction computes nothing; it only spends the one
          // cycle needed to reach DONE on the edge after the accept.
          if (r_err) begin
            r_state <= S_DONE;
          end else if (r_op == OP_MULT_MAT) begin
            r_res[r_row][r_col] <= w_mm_elem;
            r_ovf               <= r_ovf | w_mm_ovf;
            if (r_col == r_last) begin
              r_col <= '0;
              if (r_row == r_last) r_state <= S_DONE;
              else                 r_row   <= r_row + CNT_W'(1);
            end else begin
              r_col <= r_col + CNT_W'(1);
            end
          end else begin
            r_res[r_row] <= w_lane_res;
            r_ovf        <= r_ovf | w_row_ovf;
            if (r_row == r_last) r_state <= S_DONE;
            else                 r_row   <= r_row + CNT_W'(1);
          end
        end

        S_DONE: begin
          // out_valid rises on the first edge spent in DONE; in_ready returns
          // only after the handshake edge, so no accept overlaps it.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (io_mat.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_seq_ctrl.sv
// Self-checking bench for matrix_seq_ctrl (ELEM_W=8, MAX_N=5).
// Directed reset/handshake/boundary cases plus randomized instructions,
// all compared against an arithmetic reference model of the matrix ops.
module tb_matrix_seq_ctrl;
  localparam int EW  = 8;
  localparam int MN  = 5;
  localparam int MW  = MN * MN * EW;
  localparam bit SAT = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  matrix_seq_ctrl_if #(.ELEM_W(EW), .MAX_N(MN)) bus ();

  matrix_seq_ctrl #(.ELEM_W(EW), .MAX_N(MN), .SATURATE(SAT)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_mat (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          ma[MN][MN], mb[MN][MN], ex[MN][MN], lit[MN][MN];
  logic        ex_ovf, ex_err;
  int          ex_lat;
  logic [MW-1:0] got_res;

  function automatic logic [MW-1:0] pack(input int m[MN][MN]);
    logic [MW-1:0] v;
    int t;
    v = '0;
    for (int r = 0; r < MN; r++)
      for (int c = 0; c < MN; c++) begin
        t = m[r][c];
        v[(MN*MN-1-(r*MN+c))*EW +: EW] = t[EW-1:0];
      end
    return v;
  endfunction

  // Bring an exact result into the signed 8-bit range, noting overflow.
  task automatic fit(input int v, output int o);
    int w;
    o = v;
    if (v > 127 || v < -128) begin
      ex_ovf = 1'b1;
      w = v & 255;
      if (w > 127) w -= 256;
      o = SAT ? ((v > 127) ? 127 : -128) : w;
    end
  endtask

  task automatic model(input logic [4:0] ins);
    int n, op, s, o;
    n = int'(ins[1:0]) + 2;
    op = int'(ins[4:2]);
    ex_ovf = 1'b0;
    for (int r = 0; r < MN; r++)
      for (int c = 0; c < MN; c++) ex[r][c] = 0;
    ex_err = (op == 4) || (op == 7) || (n > MN);
    ex_lat = 2;
    if (!ex_err) begin
      for (int r = 0; r < n; r++)
        for (int c = 0; c < n; c++) begin
          case (op)
            0: s = ma[r][c] + mb[r][c];
            1: s = ma[r][c] - mb[r][c];
            2: begin
              s = 0;
              for (int k = 0; k < n; k++) s += ma[r][k] * mb[k][c];
            end
            3: s = ma[r][c] * mb[0][0];
            5: s = ma[c][r];
            default: s = -ma[r][c];
          endcase
          fit(s, o);
          ex[r][c] = o;
        end
      ex_lat = (op == 2) ? n * n + 1 : n + 1;
    end
  endtask

  function automatic int rnd_elem();
    case ($urandom_range(0, 7))
      0: return -128;
      1: return 127;
      2: return 100;
      3: return -100;
      default: return int'($urandom_range(0, 255)) - 128;
    endcase
  endfunction

  task automatic fill_rand();
    for (int r = 0; r < MN; r++)
      for (int c = 0; c < MN; c++) begin
        ma[r][c] = rnd_elem();
        mb[r][c] = rnd_elem();
      end
  endtask

  task automatic clear_lit();
    for (int r = 0; r < MN; r++)
      for (int c = 0; c < MN; c++) lit[r][c] = 0;
  endtask

  // Issue one instruction, measure latency, check result, stall, hand off.
  task automatic run_op(input logic [4:0] ins, input int stall, input string tag);
    logic [MW-1:0] er;
    int n;
    model(ins);
    er = pack(ex);
    @(negedge clk);
    chk({tag, ".rdy"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.instr    = ins;
    bus.mat_a    = pack(ma);
    bus.mat_b    = pack(mb);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < MN * MN; i++) begin
      bus.mat_a[i*EW +: EW] = EW'($urandom);
      bus.mat_b[i*EW +: EW] = EW'($urandom);
    end
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".lat"}, n, ex_lat);
    got_res = bus.result;
    chk({tag, ".res"}, bus.result, er);
    chk({tag, ".flg"}, {bus.ovf, bus.err}, {ex_ovf, ex_err});
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk({tag, ".hold"}, {bus.out_valid, bus.in_ready, bus.ovf, bus.err, bus.result},
          {1'b1, 1'b0, ex_ovf, ex_err, er});
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'($urandom_range(0, 1));
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk({tag, ".ho"}, {bus.out_valid, bus.in_ready}, 2'b01);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] ins;
    logic seen;
    bus.in_valid  = 1'b1;
    bus.instr     = 5'b00000;
    bus.mat_a     = '0;
    bus.mat_b     = '0;
    bus.out_ready = 1'b0;

    // Reset held two cycles with a pending request.
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.state", {bus.in_ready, bus.out_valid, bus.ovf, bus.err}, 4'b0000);
    chk("rst.res", bus.result, '0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst.rdy", bus.in_ready, 1);
    bus.in_valid = 1'b0;

    // ADD 2x2.
    fill_rand();
    ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
    mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
    run_op({3'b000, 2'b00}, 1, "add2");
    clear_lit();
    lit[0][0] = 6; lit[0][1] = 8; lit[1][0] = 10; lit[1][1] = 12;
    chk("add2.lit", got_res, pack(lit));

    // ADD 3x3 overflowing everywhere.
    fill_rand();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        ma[r][c] = 100;
        mb[r][c] = 100;
      end
    run_op({3'b000, 2'b01}, 0, "add3");
    clear_lit();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) lit[r][c] = SAT ? 127 : -56;
    chk("add3.lit", got_res, pack(lit));

    // MULT_MAT 2x2 and 5x5.
    fill_rand();
    ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
    mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
    run_op({3'b010, 2'b00}, 2, "mm2");
    clear_lit();
    lit[0][0] = 19; lit[0][1] = 22; lit[1][0] = 43; lit[1][1] = 50;
    chk("mm2.lit", got_res, pack(lit));
    fill_rand();
    run_op({3'b010, 2'b11}, 0, "mm5");

    // OPPOSITE of the minimum value.
    fill_rand();
    ma[0][0] = -128;
    run_op({3'b110, 2'b00}, 0, "neg");

    // Illegal opcodes.
    fill_rand();
    run_op({3'b100, 2'b00}, 0, "ill4");
    fill_rand();
    run_op({3'b111, 2'b10}, 1, "ill7");

    // Back-pressure with in_valid pulses during the stall.
    fill_rand();
    run_op({3'b101, 2'b10}, 10, "bp");

    // Randomized instructions.
    for (int i = 0; i < 40; i++) begin
      fill_rand();
      ins = 5'($urandom_range(0, 31));
      run_op(ins, int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
    end

    // Abort MULT_MAT 5x5 in its third EXEC cycle.
    fill_rand();
    @(negedge clk);
    chk("abort.rdy", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.instr    = {3'b010, 2'b11};
    bus.mat_a    = pack(ma);
    bus.mat_b    = pack(mb);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("abort.nov", seen, 0);
    chk("abort.idle", {bus.in_ready, bus.ovf, bus.err}, 3'b100);
    chk("abort.res", bus.result, '0);

    // Normal operation after the abort.
    fill_rand();
    run_op({3'b011, 2'b01}, 1, "post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
